// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Round-robin arbiter and sequencer that gives two requesters
//            (A and B) shared access to a 128x8 single-port RAM. The RAM has
//            a shared bidirectional data bus and a registered read.
// Ports    : i_clk, i_rst_n           - clock, asynchronous active-low reset
//            i_req_x/i_we_x/i_addr_x/ - per-port command (x = a, b), held
//            i_wdata_x                  until o_ack_x
//            o_ack_x, o_rdata_x       - one-cycle completion, read data
//            o_ram_cs/wr_e/oe/address - RAM control and address pins
//            io_ram_data              - RAM data bus, driven only during WR
//            o_busy                   - high whenever a command is in flight
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_a,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    output logic              o_ack_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic              i_req_b,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    output logic              o_ack_b,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic              o_ram_cs,
    output logic              o_ram_wr_e,
    output logic              o_ram_oe,
    output logic [ADDR_W-1:0] o_ram_address,
    inout  wire  [DATA_W-1:0] io_ram_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Latched command. The read/write direction is carried by the state
    // itself (WR versus RD_ADDR), so it needs no separate register.
    logic              cmd_port;    // 0 = A, 1 = B
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              last_b;      // 1 = B was granted most recently

    logic              elig_a;
    logic              elig_b;
    logic              grant;
    logic              grant_b;

    // Next state, grant decision and RAM pin decode. The pins depend only on
    // registered state, so they are glitch-free relative to request inputs.
    always_comb begin
        // A requester is masked during its own ack cycle: it has not yet
        // had a chance to drop or change its request.
        elig_a        = i_req_a & ~o_ack_a;
        elig_b        = i_req_b & ~o_ack_b;
        grant         = elig_a | elig_b;
        grant_b       = elig_b & (~elig_a | ~last_b);
        state_nxt     = state;
        o_ram_cs      = 1'b0;
        o_ram_wr_e    = 1'b0;
        o_ram_oe      = 1'b0;
        o_ram_address = '0;
        o_busy        = 1'b1;

        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (grant) begin
                    if (grant_b ? i_we_b : i_we_a) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end
            WR: begin
                o_ram_cs      = 1'b1;
                o_ram_wr_e    = 1'b1;
                o_ram_address = cmd_addr;
                state_nxt     = IDLE;
            end
            RD_ADDR: begin
                // RAM loads its output register this cycle; bus stays Z.
                o_ram_cs      = 1'b1;
                o_ram_address = cmd_addr;
                state_nxt     = RD_DATA;
            end
            RD_DATA: begin
                // Address is held, so the RAM re-latching the same word at
                // this edge is harmless.
                o_ram_cs      = 1'b1;
                o_ram_oe      = 1'b1;
                o_ram_address = cmd_addr;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The arbiter drives the bus only in WR, where oe is low, so the two
    // drivers can never overlap.
    assign io_ram_data = (state == WR) ? cmd_wdata : {DATA_W{1'bz}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cmd_port  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            last_b    <= 1'b1;      // A wins the first tie
            o_ack_a   <= 1'b0;
            o_ack_b   <= 1'b0;
            o_rdata_a <= '0;
            o_rdata_b <= '0;
        end else begin
            state   <= state_nxt;
            o_ack_a <= 1'b0;
            o_ack_b <= 1'b0;

            if (state == IDLE && grant) begin
                cmd_port  <= grant_b;
                cmd_addr  <= grant_b ? i_addr_b  : i_addr_a;
                cmd_wdata <= grant_b ? i_wdata_b : i_wdata_a;
                last_b    <= grant_b;
            end

            if (state == WR || state == RD_DATA) begin
                if (cmd_port) begin
                    o_ack_b <= 1'b1;
                end else begin
                    o_ack_a <= 1'b1;
                end
            end

            if (state == RD_DATA) begin
                if (cmd_port) begin
                    o_rdata_b <= io_ram_data;
                end else begin
                    o_rdata_a <= io_ram_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter with a behavioural
//            128x8 registered-read RAM on the shared bus. Expected results
//            are queued per port when a command is issued and popped when
//            the matching ack appears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, we_a, ack_a;
    logic [6:0] addr_a;
    logic [7:0] wdata_a, rdata_a;
    logic       req_b, we_b, ack_b;
    logic [6:0] addr_b;
    logic [7:0] wdata_b, rdata_b;
    logic       cs, wr_e, oe, busy;
    logic [6:0] ram_addr;
    wire  [7:0] ram_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] shadow [128];
    logic [7:0] held_a = 8'h00;
    logic [7:0] held_b = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a),
        .o_ack_a(ack_a), .o_rdata_a(rdata_a),
        .i_req_b(req_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b),
        .o_ack_b(ack_b), .o_rdata_b(rdata_b),
        .o_ram_cs(cs), .o_ram_wr_e(wr_e), .o_ram_oe(oe), .o_ram_address(ram_addr),
        .io_ram_data(ram_data), .o_busy(busy)
    );

    // Behavioural RAM: write on cs&wr_e, registered read on cs&!wr_e,
    // output driven onto the bus while cs&oe&!wr_e.
    logic [7:0] mem [128];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (cs) begin
            if (wr_e) mem[ram_addr] <= ram_data;
            else      ram_q <= mem[ram_addr];
        end
    end
    assign ram_data = (cs & oe & ~wr_e) ? ram_q : 8'hzz;

    // Continuous bus/ack monitor and scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            held_a = 8'h00;
            held_b = 8'h00;
        end else if (mon_en) begin
            checks++;
            if (wr_e && oe) begin
                failures++;
                $display("FAIL bus_contention wr_e=%0b oe=%0b required not both", wr_e, oe);
            end
            checks++;
            if (ack_a && ack_b) begin
                failures++;
                $display("FAIL dual_ack ack_a=%0b ack_b=%0b required not both", ack_a, ack_b);
            end
            checks++;
            if (!busy && (cs || wr_e || oe)) begin
                failures++;
                $display("FAIL idle_pins cs=%0b wr_e=%0b oe=%0b required 0", cs, wr_e, oe);
            end
            if (ack_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack_a at cycle %0d required no ack", cyc);
                end else begin
                    e = q_a.pop_front();
                    if (e.is_read) held_a = e.data;
                end
            end
            if (ack_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack_b at cycle %0d required no ack", cyc);
                end else begin
                    e = q_b.pop_front();
                    if (e.is_read) held_b = e.data;
                end
            end
            checks++;
            if (rdata_a !== held_a) begin
                failures++;
                $display("FAIL rdata_a got=%h required=%h cycle %0d", rdata_a, held_a, cyc);
            end
            checks++;
            if (rdata_b !== held_b) begin
                failures++;
                $display("FAIL rdata_b got=%h required=%h cycle %0d", rdata_b, held_b, cyc);
            end
        end
    end

    // Issue one command from a port, starting at a negedge, and wait for its
    // ack. lat = ack cycle minus issue cycle.
    task automatic do_op(input bit port, input bit we, input logic [6:0] a,
                         input logic [7:0] d, output int lat);
        exp_t e;
        int   t0;
        bit   got;
        e.is_read = !we;
        e.data    = we ? 8'h00 : shadow[a];
        if (we) shadow[a] = d;
        if (!port) begin
            q_a.push_back(e);
            we_a = we; addr_a = a; wdata_a = d; req_a = 1'b1;
        end else begin
            q_b.push_back(e);
            we_b = we; addr_b = a; wdata_b = d; req_b = 1'b1;
        end
        t0  = cyc;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? ack_b : ack_a) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
        if (!port) req_a = 1'b0;
        else       req_b = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL op_timeout port=%0d addr=%h got no ack required ack", port, a);
        end
    endtask

    task automatic apply_reset();
        req_a = 1'b0;
        req_b = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs, wr_e, oe, ram_addr, ack_a, ack_b, rdata_a, rdata_b, busy} !== '0) begin
            failures++;
            $display("FAIL reset_state cs=%0b wr_e=%0b oe=%0b addr=%h ack=%0b%0b rdata=%h/%h busy=%0b required all 0",
                     cs, wr_e, oe, ram_addr, ack_a, ack_b, rdata_a, rdata_b, busy);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        int   lat;
        e.is_read = 1'b0;
        e.data    = 8'h00;
        shadow[7'h10] = 8'h5A;
        q_a.push_back(e);
        we_a = 1'b1; addr_a = 7'h10; wdata_a = 8'h5A; req_a = 1'b1;
        @(negedge clk);
        checks++;
        if (!(cs === 1'b1 && wr_e === 1'b1 && oe === 1'b0 && ram_addr === 7'h10 && ram_data === 8'h5A)) begin
            failures++;
            $display("FAIL wr_cycle cs=%0b wr_e=%0b oe=%0b addr=%h bus=%h required 1 1 0 10 5a",
                     cs, wr_e, oe, ram_addr, ram_data);
        end
        @(negedge clk);
        checks++;
        if (ack_a !== 1'b1) begin
            failures++;
            $display("FAIL wr_ack_timing ack_a=%0b required 1", ack_a);
        end
        req_a = 1'b0;
        @(negedge clk);
        do_op(1'b0, 1'b0, 7'h10, 8'h00, lat);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL rd_latency got=%0d required=3", lat);
        end
    endtask

    task automatic test_tie();
        int la, lb;
        apply_reset();
        fork
            do_op(1'b0, 1'b1, 7'h01, 8'h11, la);
            do_op(1'b1, 1'b1, 7'h02, 8'h22, lb);
        join
        checks++;
        if (la != 2 || lb != 4) begin
            failures++;
            $display("FAIL tie_write_order lat_a=%0d lat_b=%0d required 2 4", la, lb);
        end
        @(negedge clk);
        fork
            do_op(1'b0, 1'b0, 7'h01, 8'h00, la);
            do_op(1'b1, 1'b0, 7'h02, 8'h00, lb);
        join
        checks++;
        if (la != 3 || lb != 6) begin
            failures++;
            $display("FAIL tie_read_order lat_a=%0d lat_b=%0d required 3 6", la, lb);
        end
    endtask

    task automatic test_alternation();
        int   lat;
        int   ports[$];
        int   cycs[$];
        exp_t e;
        do_op(1'b0, 1'b1, 7'h30, 8'hA3, lat);
        do_op(1'b1, 1'b1, 7'h40, 8'hB4, lat);
        @(negedge clk);
        e.is_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.data = shadow[7'h30]; q_a.push_back(e);
            e.data = shadow[7'h40]; q_b.push_back(e);
        end
        we_a = 1'b0; addr_a = 7'h30; req_a = 1'b1;
        we_b = 1'b0; addr_b = 7'h40; req_b = 1'b1;
        for (int i = 0; i < 60 && ports.size() < 8; i++) begin
            @(negedge clk);
            if (ack_a) begin ports.push_back(0); cycs.push_back(cyc); end
            if (ack_b) begin ports.push_back(1); cycs.push_back(cyc); end
            if (ports.size() >= 8) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        checks++;
        if (ports.size() != 8) begin
            failures++;
            $display("FAIL alt_count got=%0d required=8", ports.size());
        end
        for (int i = 1; i < ports.size(); i++) begin
            checks++;
            if (ports[i] == ports[i-1] || cycs[i] - cycs[i-1] != 3) begin
                failures++;
                $display("FAIL alt_step%0d port=%0d prev=%0d spacing=%0d required other port, 3",
                         i, ports[i], ports[i-1], cycs[i] - cycs[i-1]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL alt_drain pending=%0d/%0d busy=%0b required 0/0 0", q_a.size(), q_b.size(), busy);
        end
    endtask

    task automatic test_boundary();
        int l0, l1, l2, l3;
        do_op(1'b0, 1'b1, 7'h7F, 8'hFF, l0);
        do_op(1'b1, 1'b1, 7'h00, 8'h00, l1);
        do_op(1'b0, 1'b0, 7'h00, 8'h00, l2);
        do_op(1'b1, 1'b0, 7'h7F, 8'h00, l3);
        checks++;
        if (l0 != 2 || l1 != 2 || l2 != 3 || l3 != 3) begin
            failures++;
            $display("FAIL boundary_latency got=%0d %0d %0d %0d required 2 2 3 3", l0, l1, l2, l3);
        end
    endtask

    task automatic test_reset_mid();
        int la, lb;
        @(negedge clk);
        we_a = 1'b0; addr_a = 7'h10; req_a = 1'b1;
        @(negedge clk);
        checks++;
        if (!(cs === 1'b1 && oe === 1'b0 && wr_e === 1'b0)) begin
            failures++;
            $display("FAIL rd_addr_pins cs=%0b wr_e=%0b oe=%0b required 1 0 0", cs, wr_e, oe);
        end
        @(negedge clk);
        checks++;
        if (!(cs === 1'b1 && oe === 1'b1 && wr_e === 1'b0)) begin
            failures++;
            $display("FAIL rd_data_pins cs=%0b wr_e=%0b oe=%0b required 1 0 1", cs, wr_e, oe);
        end
        #2 rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        checks++;
        if ({cs, wr_e, oe, ram_addr, busy, ack_a, rdata_a} !== '0) begin
            failures++;
            $display("FAIL reset_mid cs=%0b wr_e=%0b oe=%0b addr=%h busy=%0b ack_a=%0b rdata_a=%h required all 0",
                     cs, wr_e, oe, ram_addr, busy, ack_a, rdata_a);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ack_a !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_ack ack_a=%0b busy=%0b required 0 0", ack_a, busy);
        end
        fork
            do_op(1'b0, 1'b1, 7'h05, 8'h33, la);
            do_op(1'b1, 1'b1, 7'h06, 8'h44, lb);
        join
        checks++;
        if (la != 2 || lb != 4) begin
            failures++;
            $display("FAIL reset_tie lat_a=%0d lat_b=%0d required 2 4", la, lb);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req_a   = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b   = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        test_reset();
        test_single();
        test_tie();
        test_alternation();
        test_boundary();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached 200000 time units required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 128x8 single-port RAM with a shared bidirectional data bus.
- Accepts independent read/write commands from ports A and B and serialises them onto the RAM's cs/wr_e/oe/address/data pins.
- Generates the two-cycle registered-read sequence the RAM requires, with no bus contention.
- Sits between two bus masters (e.g. a UART loader and a processing core) and one RAM instance.

Parameters:
ADDR_W, 7, RAM address width (128 words)
DATA_W, 8, RAM data width

Ports:
i_clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req_a  input  1  port A request; held high until o_ack_a
i_we_a  input  1  port A: 1 = write, 0 = read; stable while i_req_a high
i_addr_a  input  ADDR_W  port A address; stable while i_req_a high
i_wdata_a  input  DATA_W  port A write data; stable while i_req_a high
o_ack_a  output  1  one-cycle completion pulse for port A
o_rdata_a  output  DATA_W  port A read data, valid when o_ack_a=1 after a read, held until next A read
i_req_b, i_we_b, i_addr_b, i_wdata_b, o_ack_b, o_rdata_b: identical set for port B
o_ram_cs  output  1  RAM chip select
o_ram_wr_e  output  1  RAM write enable
o_ram_oe  output  1  RAM output enable
o_ram_address  output  ADDR_W  RAM address
io_ram_data  inout  DATA_W  RAM data bus; driven by arbiter only in WR, else high-Z
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; o_ram_cs/wr_e/oe=0, o_ram_address=0, io_ram_data=Z; o_ack_a/b=0, o_rdata_a/b=0; round-robin pointer = "B last granted" (A wins first tie).
- States: IDLE, WR, RD_ADDR, RD_DATA. State, latched command (port id, we, addr, wdata) and acks are registered; RAM pins decode from state + latched command only.
- IDLE: cs=wr_e=oe=0. Eligible = i_req_x AND NOT o_ack_x (masks requester in its ack cycle). Single eligible wins; both eligible: grant the port not granted last. On grant: latch command, update pointer, go WR if we=1 else RD_ADDR. No eligible: stay.
- WR (1 cycle): cs=1, wr_e=1, oe=0, address=latched addr, io_ram_data=latched wdata. RAM writes at this cycle's closing edge. Next: IDLE with o_ack_x=1.
- RD_ADDR (1 cycle): cs=1, wr_e=0, oe=0, bus Z. RAM latches data[addr] into its output register. Next: RD_DATA.
- RD_DATA (1 cycle): cs=1, wr_e=0, oe=1, same address (RAM re-latch of same word harmless), bus Z. At closing edge, io_ram_data captured into o_rdata_x. Next: IDLE with o_ack_x=1.
- Latency (IDLE grant cycle = k): write ack in k+2; read ack with data in k+3. Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
- o_ack_x high exactly one cycle; never both acks in the same cycle.
- Contention rule: arbiter drives bus only when wr_e=1; oe=1 only when wr_e=0. Never both in any cycle, including reset entry/exit.
- o_rdata_x unchanged by writes or by the other port's reads.
- Continuous requests from both: strict alternation A,B,A,B...
- Address 127 (max) and 0 handled identically; no address arithmetic.
- Reset mid-operation: immediate return to IDLE, RAM pins low/Z, no ack issued. A write whose WR cycle is cut by reset may or may not update RAM; requester must reissue.
- Request dropped before ack: protocol violation; behaviour unspecified, no recovery required.

Test Plan:
- A writes 0x5A to addr 0x10 (req from cycle 0) -> WR in cycle 1 with cs=1, wr_e=1, bus=0x5A; o_ack_a in cycle 2; A reads 0x10 -> o_ack_a with o_rdata_a=0x5A 3 cycles after grant.
- A and B both request in the same cycle after reset (A writes 0x11@0x01, B writes 0x22@0x02) -> A acked first, B second; reads return 0x11 and 0x22.
- Both hold continuous read requests for 12 cycles -> grants alternate A,B,A,B; each ack 3 cycles apart; rdata goes only to the acked port.
- Bus monitor over every test -> never (arbiter driving AND RAM cs&oe&!wr_e) in the same cycle; bus Z in IDLE.
- Write 0xFF@127 then 0x00@0, read both -> 0xFF and 0x00; no aliasing.
- Assert i_rst_n=0 in RD_DATA -> pins low/Z within the same cycle, no o_ack, o_rdata=0, state IDLE; after release A wins the first tie.
